// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider with valid/ready handshakes
module seq_divider #(
    parameter int DIVIDEND = 16,
    parameter int DIVISOR  = 8,
    parameter int SIGNED   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIVIDEND-1:0] dividend,
    input  logic [DIVISOR-1:0]  divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIVIDEND-1:0] quotient,
    output logic [DIVISOR-1:0]  remainder,
    output logic                div_by_zero
);

    localparam int CW = $clog2(DIVIDEND);
    localparam logic [DIVIDEND-1:0] ONE_A = {{(DIVIDEND-1){1'b0}}, 1'b1};
    localparam logic [DIVISOR-1:0]  ONE_B = {{(DIVISOR-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [DIVIDEND-1:0] dq_q;      // dividend bits shift out of the top, quotient bits in at the bottom
    logic [DIVISOR-1:0]  rem_q;     // partial remainder, always < |divisor| between steps
    logic [DIVISOR-1:0]  dsr_q;     // |divisor|
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [DIVIDEND-1:0] quotient_q;
    logic [DIVISOR-1:0]  remainder_q;
    logic                dbz_q;

    logic                a_neg;
    logic                b_neg;
    logic [DIVIDEND-1:0] a_mag;
    logic [DIVISOR-1:0]  b_mag;
    logic [DIVISOR:0]    shifted;
    logic [DIVISOR+1:0]  trial;
    logic                take;
    logic [DIVISOR-1:0]  rem_d;
    logic [DIVIDEND-1:0] dq_d;
    logic [DIVIDEND-1:0] quo_fix;
    logic [DIVISOR-1:0]  rem_fix;
    logic                unused_trial_bit;

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    // The shifted value is at most 2*|divisor|-1, so bit DIVISOR of a kept difference is always 0.
    assign unused_trial_bit = trial[DIVISOR];

    // Operand magnitudes, one restoring step, and the sign fix-up of the step's result
    always_comb begin
        a_neg   = (SIGNED != 0) && dividend[DIVIDEND-1];
        b_neg   = (SIGNED != 0) && divisor[DIVISOR-1];
        a_mag   = a_neg ? (~dividend + ONE_A) : dividend;
        b_mag   = b_neg ? (~divisor + ONE_B) : divisor;
        shifted = {rem_q, dq_q[DIVIDEND-1]};
        trial   = {1'b0, shifted} - {2'b00, dsr_q};
        take    = ~trial[DIVISOR+1];
        rem_d   = take ? trial[DIVISOR-1:0] : shifted[DIVISOR-1:0];
        dq_d    = {dq_q[DIVIDEND-2:0], take};
        quo_fix = neg_quo_q ? (~dq_d + ONE_A) : dq_d;
        rem_fix = neg_rem_q ? (~rem_d + ONE_B) : rem_d;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend[DIVISOR-1:0];
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dq_q      <= a_mag;
                            dsr_q     <= b_mag;
                            rem_q     <= '0;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            cnt_q     <= CW'(DIVIDEND - 1);
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    dq_q  <= dq_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        quotient_q  <= quo_fix;
                        remainder_q <= rem_fix;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
